// File: rtl/tone_generator_pkg.sv
// Shared encodings for the tone generator: FSM states, burst/continuous mode
// values and the bit positions inside the status byte read by firmware.
package tone_generator_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic MODE_CONT  = 1'b0;
   localparam logic MODE_BURST = 1'b1;

   localparam int ST_BUSY = 7;
   localparam int ST_DONE = 6;
   localparam int ST_TONE = 5;
   localparam int ST_MODE = 4;

endpackage

// File: rtl/tone_generator_reload_counter.sv
// Down counter with synchronous reload; holds at zero and flags it so the
// owner can decide when to reload.
module reload_counter #(
   parameter int CNT_W = 25
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reload,
   input  logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else if (reload)
         cnt_q <= value;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - 1'b1;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/tone_generator.sv
// Square-wave generator driven by the microcontroller frequency word: half-period
// of contador clocks, continuous or as a burst of N pulses, with a status byte.
module tone_generator
   import tone_generator_pkg::*;
#(
   parameter int CNT_W   = 25,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CNT_W-1:0]   contador,
   input  logic               load,
   input  logic               mode,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               stop,
   output logic               tone,
   output logic               busy,
   output logic               done,
   output logic [7:0]         status
);

   state_t             state_q, state_d;
   logic               tone_q, tone_d;
   logic               done_q, done_d;
   logic               mode_q, mode_d;
   logic [CNT_W-1:0]   p_q, p_d;
   logic [BURST_W-1:0] n_q, n_d;
   logic [BURST_W-1:0] pulses_q, pulses_d;
   logic [BURST_W-1:0] n_last;
   logic               reload;
   logic [CNT_W-1:0]   reload_val;
   logic               zero;

   reload_counter #(.CNT_W(CNT_W)) u_half_cnt (
      .clk    (clk),
      .reset  (reset),
      .reload (reload),
      .value  (reload_val),
      .zero   (zero)
   );

   // N==0 wraps to all-ones here, giving 2**BURST_W pulses per burst.
   assign n_last = n_q - 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         tone_q   <= 1'b0;
         done_q   <= 1'b0;
         mode_q   <= MODE_CONT;
         p_q      <= '0;
         n_q      <= '0;
         pulses_q <= '0;
      end else begin
         state_q  <= state_d;
         tone_q   <= tone_d;
         done_q   <= done_d;
         mode_q   <= mode_d;
         p_q      <= p_d;
         n_q      <= n_d;
         pulses_q <= pulses_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tone_d     = tone_q;
      done_d     = done_q;
      mode_d     = mode_q;
      p_d        = p_q;
      n_d        = n_q;
      pulses_d   = pulses_q;
      reload     = 1'b0;
      reload_val = '0;
      if (stop) begin
         state_d = S_IDLE;
         tone_d  = 1'b0;
      end else if (load) begin
         if (contador != '0) begin
            p_d        = contador;
            mode_d     = mode;
            n_d        = burst_len;
            done_d     = 1'b0;
            pulses_d   = '0;
            tone_d     = 1'b1;
            state_d    = S_RUN;
            reload     = 1'b1;
            reload_val = contador - 1'b1;
         end else begin
            // Zero frequency word acts as a silent stop.
            state_d = S_IDLE;
            tone_d  = 1'b0;
         end
      end else if (state_q == S_RUN && zero) begin
         reload_val = p_q - 1'b1;
         if (tone_q) begin
            tone_d = 1'b0;
            reload = 1'b1;
         end else if (mode_q == MODE_BURST && pulses_q == n_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end else begin
            tone_d = 1'b1;
            reload = 1'b1;
            if (mode_q == MODE_BURST)
               pulses_d = pulses_q + 1'b1;
         end
      end
   end

   assign tone = tone_q;
   assign busy = (state_q == S_RUN);
   assign done = done_q;

   always_comb begin
      status          = 8'h00;
      status[ST_BUSY] = busy;
      status[ST_DONE] = done_q;
      status[ST_TONE] = tone_q;
      status[ST_MODE] = mode_q;
   end

endmodule
